// File: rtl/ucsbece154b_bp_pkg.sv
// Shared definitions for the ucsbece154b branch predictor: E-stage opcodes,
// two-bit PHT counter encodings and a constant-foldable log2 helper.
package ucsbece154b_bp_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/ucsbece154b_branch_if.sv
// Fetch-side prediction and E-side training signals between the datapath
// (master) and the branch predictor (slave).
interface ucsbece154b_branch_if #(
  parameter int NUM_GHR_BITS = 5
);
  logic [31:0]             pc_i;
  logic [NUM_GHR_BITS-1:0] phtindex_o;
  logic                    branch_taken_o;
  logic [31:0]             btb_target_o;
  logic [6:0]              op_e_i;
  logic [31:0]             pc_e_i;
  logic [NUM_GHR_BITS-1:0] phtindex_e_i;
  logic                    taken_e_i;
  logic [31:0]             target_e_i;
  logic                    stall_e_i;

  modport master (
    output pc_i, op_e_i, pc_e_i, phtindex_e_i, taken_e_i, target_e_i, stall_e_i,
    input  phtindex_o, branch_taken_o, btb_target_o
  );

  modport slave (
    input  pc_i, op_e_i, pc_e_i, phtindex_e_i, taken_e_i, target_e_i, stall_e_i,
    output phtindex_o, branch_taken_o, btb_target_o
  );
endinterface

// File: rtl/ucsbece154b_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous write.
// Only the valid bits are reset; tag/target/is_jump are meaningless while invalid.
module ucsbece154b_btb
  import ucsbece154b_bp_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rd_pc_i,
  output logic        rd_hit_o,
  output logic [31:0] rd_target_o,
  output logic        rd_is_jump_o,
  input  logic        we_i,
  input  logic [31:0] wr_pc_i,
  input  logic [31:0] wr_target_i,
  input  logic        wr_is_jump_i
);

  localparam int IDX   = clog2(NUM_BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic [NUM_BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]           tag_q     [NUM_BTB_ENTRIES];
  logic [31:0]                target_q  [NUM_BTB_ENTRIES];
  logic                       is_jump_q [NUM_BTB_ENTRIES];

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             unused_pc_bits;

  assign rd_idx = rd_pc_i[IDX+1:2];
  assign rd_tag = rd_pc_i[31:IDX+2];
  assign wr_idx = wr_pc_i[IDX+1:2];
  assign wr_tag = wr_pc_i[31:IDX+2];
  assign unused_pc_bits = &{1'b0, rd_pc_i[1:0], wr_pc_i[1:0]};

  assign rd_hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target_o  = rd_hit_o ? target_q[rd_idx] : 32'h0;
  assign rd_is_jump_o = is_jump_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx]     <= wr_tag;
      target_q[wr_idx]  <= wr_target_i;
      is_jump_q[wr_idx] <= wr_is_jump_i;
    end
  end

endmodule

// File: rtl/ucsbece154b_branch.sv
// Gshare predictor: PHT of two-bit counters indexed by PC^GHR plus a BTB.
// GHR is architectural and only shifts on resolved, unstalled branches.
module ucsbece154b_branch
  import ucsbece154b_bp_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input logic                clk,
  input logic                reset,
  ucsbece154b_branch_if.slave bp
);

  localparam int PHT_SIZE = 1 << NUM_GHR_BITS;

  pht_state_t              pht_q [PHT_SIZE];
  logic [NUM_GHR_BITS-1:0] ghr_q;
  logic [NUM_GHR_BITS-1:0] phtindex_f;
  pht_state_t              pht_cur, pht_next;
  logic                    is_branch_e, is_jump_e, train_branch, btb_we;
  logic                    btb_hit, btb_is_jump;
  logic [31:0]             btb_target;

  assign phtindex_f    = bp.pc_i[NUM_GHR_BITS+1:2] ^ ghr_q;
  assign bp.phtindex_o = phtindex_f;

  assign is_branch_e  = (bp.op_e_i == OP_BRANCH);
  assign is_jump_e    = (bp.op_e_i == OP_JAL) || (bp.op_e_i == OP_JALR);
  assign train_branch = is_branch_e && !bp.stall_e_i;
  // Gate with reset so a training write cannot land in the reset cycle.
  assign btb_we = reset && !bp.stall_e_i &&
                  ((is_branch_e && bp.taken_e_i) || is_jump_e);

  ucsbece154b_btb #(
    .NUM_BTB_ENTRIES(NUM_BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .rd_pc_i      (bp.pc_i),
    .rd_hit_o     (btb_hit),
    .rd_target_o  (btb_target),
    .rd_is_jump_o (btb_is_jump),
    .we_i         (btb_we),
    .wr_pc_i      (bp.pc_e_i),
    .wr_target_i  (bp.target_e_i),
    .wr_is_jump_i (is_jump_e)
  );

  assign bp.branch_taken_o = btb_hit && (btb_is_jump || pht_q[phtindex_f][1]);
  assign bp.btb_target_o   = btb_target;

  always_comb begin
    pht_cur  = pht_q[bp.phtindex_e_i];
    pht_next = pht_cur;
    if (bp.taken_e_i) begin
      if (pht_cur != ST) pht_next = pht_state_t'(pht_cur + 2'd1);
    end else begin
      if (pht_cur != SNT) pht_next = pht_state_t'(pht_cur - 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PHT_SIZE; i++) pht_q[i] <= WNT;
      ghr_q <= '0;
    end else if (train_branch) begin
      pht_q[bp.phtindex_e_i] <= pht_next;
      ghr_q <= {ghr_q[NUM_GHR_BITS-2:0], bp.taken_e_i};
    end
  end

endmodule

// File: tb/tb_ucsbece154b_branch.sv
// Randomized and directed bench for the gshare predictor, checked against an
// array-based model of BTB, PHT counters and global history.
module tb_ucsbece154b_branch;

  localparam int N_BTB = 32;
  localparam int N_GHR = 5;
  localparam logic [6:0] OPB  = 7'b1100011;
  localparam logic [6:0] OPJ  = 7'b1101111;
  localparam logic [6:0] OPJR = 7'b1100111;
  localparam logic [6:0] OPR  = 7'b0110011;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  ucsbece154b_branch_if #(.NUM_GHR_BITS(N_GHR)) bus ();

  ucsbece154b_branch #(
    .NUM_BTB_ENTRIES(N_BTB),
    .NUM_GHR_BITS   (N_GHR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bp   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: plain arrays and integer counters 0..3.
  bit          mValid  [N_BTB];
  logic [31:0] mTag    [N_BTB];
  logic [31:0] mTarget [N_BTB];
  bit          mJump   [N_BTB];
  int          mPht    [1 << N_GHR];
  int          mGhr;

  function automatic int btbIdx(input logic [31:0] pc);
    return int'((pc >> 2) % N_BTB);
  endfunction

  function automatic logic [31:0] btbTag(input logic [31:0] pc);
    return pc >> 7;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  // Model update sees the same inputs the DUT samples at this edge.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_BTB; i++) mValid[i] = 0;
      for (int i = 0; i < (1 << N_GHR); i++) mPht[i] = 1;
      mGhr = 0;
    end else if (!bus.stall_e_i) begin
      if (bus.op_e_i == OPB) begin
        int e;
        e = int'(bus.phtindex_e_i);
        if (bus.taken_e_i) mPht[e] = (mPht[e] == 3) ? 3 : mPht[e] + 1;
        else               mPht[e] = (mPht[e] == 0) ? 0 : mPht[e] - 1;
        mGhr = ((mGhr * 2) + int'(bus.taken_e_i)) % (1 << N_GHR);
        if (bus.taken_e_i) begin
          mValid[btbIdx(bus.pc_e_i)]  = 1;
          mTag[btbIdx(bus.pc_e_i)]    = btbTag(bus.pc_e_i);
          mTarget[btbIdx(bus.pc_e_i)] = bus.target_e_i;
          mJump[btbIdx(bus.pc_e_i)]   = 0;
        end
      end else if (bus.op_e_i == OPJ || bus.op_e_i == OPJR) begin
        mValid[btbIdx(bus.pc_e_i)]  = 1;
        mTag[btbIdx(bus.pc_e_i)]    = btbTag(bus.pc_e_i);
        mTarget[btbIdx(bus.pc_e_i)] = bus.target_e_i;
        mJump[btbIdx(bus.pc_e_i)]   = 1;
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [31:0] pc, input logic [6:0] op,
                               input logic [31:0] pce, input logic [4:0] idxe, input logic tk,
                               input logic [31:0] tgt, input logic stall);
    int bi, pi;
    bit hit;
    @(negedge clk);
    reset            = rst;
    bus.pc_i         = pc;
    bus.op_e_i       = op;
    bus.pc_e_i       = pce;
    bus.phtindex_e_i = idxe;
    bus.taken_e_i    = tk;
    bus.target_e_i   = tgt;
    bus.stall_e_i    = stall;
    #1;
    bi  = btbIdx(pc);
    pi  = int'((pc >> 2) % (1 << N_GHR)) ^ mGhr;
    hit = mValid[bi] && (mTag[bi] == btbTag(pc));
    checkOutput("phtidx", 32'(bus.phtindex_o), 32'(pi));
    checkOutput("taken", 32'(bus.branch_taken_o), 32'(hit && (mJump[bi] || mPht[pi] >= 2)));
    checkOutput("target", bus.btb_target_o, hit ? mTarget[bi] : 32'h0);
  endtask

  task automatic fetch(input logic [31:0] pc);
    applyStimulus(1'b1, pc, 7'h0, 32'h0, 5'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] pcPool [8];
    logic [6:0]  op;
    logic        tk;
    int          r;
    pcPool = '{32'h2C, 32'h4C, 32'hCC, 32'h74, 32'h78, 32'h1074, 32'h10, 32'h90};
    checkCount = 0;
    passCount  = 0;
    reset = 1'b0;
    bus.pc_i = '0; bus.op_e_i = '0; bus.pc_e_i = '0; bus.phtindex_e_i = '0;
    bus.taken_e_i = 1'b0; bus.target_e_i = '0; bus.stall_e_i = 1'b0;
    repeat (2) @(posedge clk);

    fetch(32'h2C);
    checkOutput("rst_idx", 32'(bus.phtindex_o), 32'h0B);
    checkOutput("rst_taken", 32'(bus.branch_taken_o), 32'h0);

    applyStimulus(1'b1, 32'h4C, OPJ, 32'h4C, 5'h0, 1'b1, 32'h64, 1'b0);
    checkOutput("jal_no_bypass", 32'(bus.branch_taken_o), 32'h0);
    fetch(32'h4C);
    checkOutput("jal_taken", 32'(bus.branch_taken_o), 32'h1);
    checkOutput("jal_target", bus.btb_target_o, 32'h64);
    fetch(32'hCC);
    checkOutput("alias_miss", 32'(bus.branch_taken_o), 32'h0);

    repeat (2) applyStimulus(1'b1, 32'h0, OPB, 32'h74, 5'h1D, 1'b1, 32'h6C, 1'b0);
    fetch(32'h74);
    checkOutput("ghr_00011", 32'(bus.phtindex_o), 32'h1E);
    checkOutput("beq_target", bus.btb_target_o, 32'h6C);

    repeat (5) applyStimulus(1'b1, 32'h0, OPB, 32'h74, 5'h1D, 1'b0, 32'h6C, 1'b0);
    fetch(32'h74);
    checkOutput("ghr_cleared", 32'(bus.phtindex_o), 32'h1D);
    checkOutput("pht_floor", 32'(bus.branch_taken_o), 32'h0);

    applyStimulus(1'b1, 32'h0, OPB, 32'h10, 5'h04, 1'b1, 32'h500, 1'b1);
    applyStimulus(1'b1, 32'h0, OPR, 32'h10, 5'h04, 1'b1, 32'h500, 1'b0);
    fetch(32'h10);
    checkOutput("no_train_idx", 32'(bus.phtindex_o), 32'h04);
    checkOutput("no_train_btb", bus.btb_target_o, 32'h0);

    applyStimulus(1'b1, 32'h0, OPJ,  32'h10, 5'h0, 1'b1, 32'h100, 1'b0);
    applyStimulus(1'b1, 32'h0, OPJR, 32'h90, 5'h0, 1'b1, 32'h200, 1'b0);
    applyStimulus(1'b1, 32'h0, OPB,  32'h2C, 5'h3, 1'b1, 32'h300, 1'b0);
    fetch(32'h90);
    checkOutput("jalr_target", bus.btb_target_o, 32'h200);
    applyStimulus(1'b0, 32'h10, OPJ, 32'h4C, 5'h0, 1'b1, 32'h999, 1'b0);
    fetch(32'h10);
    checkOutput("mid_rst_miss", bus.btb_target_o, 32'h0);
    fetch(32'h2C);
    checkOutput("mid_rst_ghr", 32'(bus.phtindex_o), 32'h0B);
    fetch(32'h4C);
    checkOutput("rst_blocks_train", 32'(bus.branch_taken_o), 32'h0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        5:       op = OPJ;
        6:       op = OPJR;
        7:       op = OPR;
        8:       op = 7'h0;
        default: op = OPB;
      endcase
      tk = (op == OPJ || op == OPJR) ? 1'b1 : ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 149) != 0, pcPool[$urandom_range(0, 7)], op,
                    pcPool[$urandom_range(0, 7)], 5'($urandom_range(0, 31)), tk,
                    $urandom & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
